dmem_arbiter: RTL and testbench

Two-requester arbiter that shares the single data memory port between the MIPS CPU load/store path (m0) and a debug/DMA master (m1). Each requester uses a req/ack handshake. The arbiter latches the winning command, drives the memory for exactly one cycle, captures read data, and returns a one-cycle ack. It sits between the requesters and the data memory; the data-memory side is unchanged (comb read, write on clk edge while we=1).

---
 rtl/dmem_arbiter.sv | 131 +++++++++++++
 tb/tb_dmem_arbiter.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-requester data memory arbiter with req/ack handshake
// Winner is latched at grant; memory is driven for one ACCESS cycle, then a one-cycle ack.
module dmem_arbiter #(
  parameter int RR_EN = 1,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wd,
  input  logic [1:0]    m0_size,
  output logic          m0_ack,
  output logic          m0_err,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wd,
  input  logic [1:0]    m1_size,
  output logic          m1_ack,
  output logic          m1_err,
  output logic [DW-1:0] m1_rdata,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wd,
  output logic [1:0]    mem_size,
  input  logic [DW-1:0] mem_rd,
  output logic          owner,
  output logic          busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t        state;
  logic          last_grant;
  logic          cmd_we;
  logic          cmd_err;

  logic          winner;
  logic          sel_we;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wd;
  logic [1:0]    sel_size;
  logic          sel_err;

  always_comb begin
    winner = 1'b0;
    if (m0_req && m1_req)
      winner = (RR_EN != 0) ? ~last_grant : 1'b0;
    else
      winner = m1_req;

    sel_we   = winner ? m1_we   : m0_we;
    sel_addr = winner ? m1_addr : m0_addr;
    sel_wd   = winner ? m1_wd   : m0_wd;
    sel_size = winner ? m1_size : m0_size;

    sel_err = 1'b0;
    case (sel_size)
      2'b01:   sel_err = sel_addr[0];
      2'b10:   sel_err = (sel_addr[1:0] != 2'b00);
      2'b11:   sel_err = 1'b1;
      default: sel_err = 1'b0;
    endcase
  end

  // mem_we is a register set at grant so it is high for exactly the ACCESS cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      cmd_we     <= 1'b0;
      cmd_err    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wd     <= '0;
      mem_size   <= 2'b00;
      owner      <= 1'b0;
      busy       <= 1'b0;
      m0_ack     <= 1'b0;
      m0_err     <= 1'b0;
      m0_rdata   <= '0;
      m1_ack     <= 1'b0;
      m1_err     <= 1'b0;
      m1_rdata   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (m0_req || m1_req) begin
            state      <= ACCESS;
            busy       <= 1'b1;
            owner      <= winner;
            last_grant <= winner;
            cmd_we     <= sel_we;
            cmd_err    <= sel_err;
            mem_we     <= sel_we & ~sel_err;
            mem_addr   <= sel_addr;
            mem_wd     <= sel_wd;
            mem_size   <= sel_size;
          end
        end
        ACCESS: begin
          state  <= RESP;
          mem_we <= 1'b0;
          if (!owner) begin
            m0_ack <= 1'b1;
            m0_err <= cmd_err;
            if (!cmd_we && !cmd_err) m0_rdata <= mem_rd;
          end else begin
            m1_ack <= 1'b1;
            m1_err <= cmd_err;
            if (!cmd_we && !cmd_err) m1_rdata <= mem_rd;
          end
        end
        RESP: begin
          state  <= IDLE;
          busy   <= 1'b0;
          m0_ack <= 1'b0;
          m0_err <= 1'b0;
          m1_ack <= 1'b0;
          m1_err <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - directed self-checking bench for dmem_arbiter
// Two instances: round-robin (main) and fixed priority (f_ prefix), sharing one memory model.
module tb_dmem_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        m0_req, m0_we, m0_ack, m0_err;
  logic [31:0] m0_addr, m0_wd, m0_rdata;
  logic [1:0]  m0_size;
  logic        m1_req, m1_we, m1_ack, m1_err;
  logic [31:0] m1_addr, m1_wd, m1_rdata;
  logic [1:0]  m1_size;
  logic        mem_we, owner, busy;
  logic [31:0] mem_addr, mem_wd, mem_rd;
  logic [1:0]  mem_size;

  logic        f_m0_req, f_m0_we, f_m0_ack, f_m0_err;
  logic [31:0] f_m0_addr, f_m0_wd, f_m0_rdata;
  logic [1:0]  f_m0_size;
  logic        f_m1_req, f_m1_we, f_m1_ack, f_m1_err;
  logic [31:0] f_m1_addr, f_m1_wd, f_m1_rdata;
  logic [1:0]  f_m1_size;
  logic        f_mem_we, f_owner, f_busy;
  logic [31:0] f_mem_addr, f_mem_wd, f_mem_rd;
  logic [1:0]  f_mem_size;

  logic [31:0] mem [0:4095];
  logic        pl_en;
  logic [11:0] pl_idx;
  logic [31:0] pl_data;

  assign mem_rd   = mem[mem_addr[13:2]];
  assign f_mem_rd = mem[f_mem_addr[13:2]];

  always @(posedge clk) begin
    if (pl_en) mem[pl_idx] <= pl_data;
    else if (mem_we) mem[mem_addr[13:2]] <= mem_wd;
  end

  dmem_arbiter #(.RR_EN(1), .AW(32), .DW(32)) u_rr (
    .clk(clk), .rst(rst_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wd(m0_wd), .m0_size(m0_size),
    .m0_ack(m0_ack), .m0_err(m0_err), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wd(m1_wd), .m1_size(m1_size),
    .m1_ack(m1_ack), .m1_err(m1_err), .m1_rdata(m1_rdata),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_size(mem_size),
    .mem_rd(mem_rd), .owner(owner), .busy(busy)
  );

  dmem_arbiter #(.RR_EN(0), .AW(32), .DW(32)) u_fp (
    .clk(clk), .rst(rst_n),
    .m0_req(f_m0_req), .m0_we(f_m0_we), .m0_addr(f_m0_addr), .m0_wd(f_m0_wd), .m0_size(f_m0_size),
    .m0_ack(f_m0_ack), .m0_err(f_m0_err), .m0_rdata(f_m0_rdata),
    .m1_req(f_m1_req), .m1_we(f_m1_we), .m1_addr(f_m1_addr), .m1_wd(f_m1_wd), .m1_size(f_m1_size),
    .m1_ack(f_m1_ack), .m1_err(f_m1_err), .m1_rdata(f_m1_rdata),
    .mem_we(f_mem_we), .mem_addr(f_mem_addr), .mem_wd(f_mem_wd), .mem_size(f_mem_size),
    .mem_rd(f_mem_rd), .owner(f_owner), .busy(f_busy)
  );

  int checks = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic preload(input logic [11:0] idx, input logic [31:0] data);
    pl_en = 1'b1; pl_idx = idx; pl_data = data;
    @(posedge clk); #1;
    pl_en = 1'b0;
  endtask

  // Called at a negedge in IDLE; returns at a negedge in IDLE one cycle after the access.
  task automatic run_one(input logic m, input logic we, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [1:0] size,
                         input logic exp_err, input logic [31:0] exp_rd);
    if (m) begin m1_req = 1; m1_we = we; m1_addr = addr; m1_wd = wd; m1_size = size; end
    else   begin m0_req = 1; m0_we = we; m0_addr = addr; m0_wd = wd; m0_size = size; end
    @(negedge clk);
    check_eq("acc_busy", busy, 1);
    check_eq("acc_owner", owner, m);
    check_eq("acc_mem_we", mem_we, we & ~exp_err);
    check_eq("acc_mem_addr", mem_addr, addr);
    m0_req = 0; m1_req = 0;
    @(negedge clk);
    check_eq("resp_ack", m ? m1_ack : m0_ack, 1);
    check_eq("resp_err", m ? m1_err : m0_err, exp_err);
    check_eq("resp_other_ack", m ? m0_ack : m1_ack, 0);
    check_eq("resp_mem_we", mem_we, 0);
    check_eq("resp_rdata", m ? m1_rdata : m0_rdata, exp_rd);
    @(negedge clk);
    check_eq("idle_ack", m ? m1_ack : m0_ack, 0);
    check_eq("idle_busy", busy, 0);
    @(negedge clk);
    check_eq("no_second_access", busy, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 0; pl_en = 0; pl_idx = '0; pl_data = '0;
    m0_req = 0; m0_we = 0; m0_addr = '0; m0_wd = '0; m0_size = 2'b00;
    m1_req = 0; m1_we = 0; m1_addr = '0; m1_wd = '0; m1_size = 2'b00;
    f_m0_req = 0; f_m0_we = 0; f_m0_addr = '0; f_m0_wd = '0; f_m0_size = 2'b00;
    f_m1_req = 0; f_m1_we = 0; f_m1_addr = '0; f_m1_wd = '0; f_m1_size = 2'b00;

    preload(12'h004, 32'h0000_0000);
    preload(12'h008, 32'h1234_5678);
    preload(12'h00C, 32'h0000_0000);
    preload(12'h010, 32'hA0A0_A0A0);
    preload(12'h011, 32'hB1B1_B1B1);
    preload(12'h400, 32'hCAFE_F00D);

    @(negedge clk);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_owner", owner, 0);
    check_eq("rst_mem_we", mem_we, 0);
    check_eq("rst_mem_addr", mem_addr, 0);
    check_eq("rst_mem_size", mem_size, 0);
    check_eq("rst_m0_ack", m0_ack, 0);
    check_eq("rst_m1_rdata", m1_rdata, 0);
    rst_n = 1;
    @(negedge clk);
    check_eq("idle_no_req", busy, 0);

    // m0 word write then read back
    run_one(0, 1, 32'h10, 32'hDEAD_BEEF, 2'b10, 0, 32'h0);
    check_eq("t1_mem_written", mem[4], 32'hDEAD_BEEF);
    run_one(0, 0, 32'h10, 32'h0, 2'b10, 0, 32'hDEAD_BEEF);

    // m1 misaligned half and reserved size: rejected, memory untouched
    run_one(1, 1, 32'h1001, 32'h1111_2222, 2'b01, 1, 32'h0);
    check_eq("t4_mem_keep_half", mem[12'h400], 32'hCAFE_F00D);
    run_one(1, 1, 32'h1000, 32'h3333_4444, 2'b11, 1, 32'h0);
    check_eq("t4_mem_keep_rsvd", mem[12'h400], 32'hCAFE_F00D);

    // m1 single-cycle read pulse
    run_one(1, 0, 32'h20, 32'h0, 2'b10, 0, 32'h1234_5678);

    // round robin with both requesters held (last grant was m1, so m0 first)
    m0_req = 1; m0_we = 0; m0_addr = 32'h40; m0_size = 2'b10;
    m1_req = 1; m1_we = 0; m1_addr = 32'h44; m1_size = 2'b10;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_eq("rr_owner", owner, i % 2);
      @(negedge clk);
      check_eq("rr_m0_ack", m0_ack, (i % 2) == 0);
      check_eq("rr_m1_ack", m1_ack, (i % 2) == 1);
      check_eq("rr_rdata", (i % 2) ? m1_rdata : m0_rdata,
               (i % 2) ? 32'hB1B1_B1B1 : 32'hA0A0_A0A0);
      @(negedge clk);
      check_eq("rr_idle", busy, 0);
      if (i == 3) begin m0_req = 0; m1_req = 0; end
    end
    @(negedge clk);
    check_eq("rr_done", busy, 0);

    // reset during ACCESS of an m0 write
    m0_req = 1; m0_we = 1; m0_addr = 32'h30; m0_wd = 32'h55AA_55AA; m0_size = 2'b10;
    @(posedge clk); #2;
    check_eq("t5_we_before_rst", mem_we, 1);
    rst_n = 0; #1;
    check_eq("t5_we_async", mem_we, 0);
    check_eq("t5_busy", busy, 0);
    check_eq("t5_mem_addr", mem_addr, 0);
    check_eq("t5_m0_rdata", m0_rdata, 0);
    check_eq("t5_m1_rdata", m1_rdata, 0);
    m0_req = 0;
    @(negedge clk);
    @(negedge clk);
    check_eq("t5_no_ack", m0_ack, 0);
    check_eq("t5_mem_kept", mem[12'h00C], 32'h0);
    rst_n = 1;
    @(negedge clk);
    run_one(0, 0, 32'h10, 32'h0, 2'b10, 0, 32'hDEAD_BEEF);

    // fixed priority instance: m0 wins every tie
    f_m0_req = 1; f_m0_addr = 32'h40; f_m0_size = 2'b10;
    f_m1_req = 1; f_m1_addr = 32'h44; f_m1_size = 2'b10;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("fp_owner", f_owner, 0);
      @(negedge clk);
      check_eq("fp_m0_ack", f_m0_ack, 1);
      check_eq("fp_m1_ack", f_m1_ack, 0);
      @(negedge clk);
      if (i == 2) f_m0_req = 0;
    end
    @(negedge clk);
    check_eq("fp_m1_owner", f_owner, 1);
    f_m1_req = 0;
    @(negedge clk);
    check_eq("fp_m1_ack_late", f_m1_ack, 1);
    check_eq("fp_m1_rdata", f_m1_rdata, 32'hB1B1_B1B1);
    @(negedge clk);
    check_eq("fp_idle", f_busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
